// File: rtl/fns_encoder_iter_pkg.sv
// Shared types and constant functions for the iterative FNS encoder.
package fns_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  function automatic logic [63:0] fib(input int k);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Widest binary word that always fits below Fib(n+2).
  function automatic int fns_dw(input int n);
    logic [63:0] f;
    int          lg;
    f  = fib(n + 2);
    lg = 0;
    for (int i = 0; i < 64; i++)
      if (f[i]) lg = i;
    return lg;
  endfunction

endpackage

// File: rtl/fns_encoder_iter_if.sv
// Upstream/downstream handshake bundle of the FNS encoder.
// out_err is present only when FNS_ENC_RANGE_CHK_EN is defined.
interface fns_encoder_iter_if #(
  parameter int N  = 27,
  parameter int DW = fns_pkg::fns_dw(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] datain;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  codeout;
  logic          busy;
`ifdef FNS_ENC_RANGE_CHK_EN
  logic          out_err;
`endif

  modport slave (
    input  in_valid, datain, out_ready,
`ifdef FNS_ENC_RANGE_CHK_EN
    output out_err,
`endif
    output in_ready, out_valid, codeout, busy
  );

  modport master (
    output in_valid, datain, out_ready,
`ifdef FNS_ENC_RANGE_CHK_EN
    input  out_err,
`endif
    input  in_ready, out_valid, codeout, busy
  );
endinterface

// File: rtl/fns_enc_slice.sv
// One FNS code-bit decision: pick c[k] from the residue and weights, then subtract.
module fns_enc_slice #(
  parameter int DW = 18,
  parameter int WW = DW + 1
) (
  input  logic [DW-1:0] r,
  input  logic          c_prev,
  input  logic [WW-1:0] w_k,
  input  logic [WW-1:0] w_k1,
  output logic          c_k,
  output logic [DW-1:0] r_next
);
  logic [WW-1:0] r_ext;
  logic [WW-1:0] r_sub;

  assign r_ext = WW'(r);
  assign r_sub = r_ext - w_k;

  // Between the two weights either choice is legal; repeating the
  // previous bit is what keeps 010/101 out of the codeword.
  always_comb begin
    if (r_ext >= w_k1)     c_k = 1'b1;
    else if (r_ext < w_k)  c_k = 1'b0;
    else                   c_k = c_prev;
  end

  assign r_next = c_k ? r_sub[DW-1:0] : r;
endmodule

// File: rtl/fns_encoder_iter.sv
// Multi-cycle binary -> FNS encoder, STEP code bits per RUN cycle, MSB first.
// Optional range check on input compiled in with FNS_ENC_RANGE_CHK_EN.
module fns_encoder_iter
  import fns_pkg::*;
#(
  parameter int N    = 27,
  parameter int STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  fns_encoder_iter_if.slave bus
);
  localparam int DW = fns_dw(N);
  localparam int WW = DW + 1;
  localparam int IW = $clog2(N + 1);
  localparam int CW = $clog2(N);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
  localparam logic [IW-1:0] STEP_I  = IW'(STEP);
  localparam logic [IW-1:0] ONE     = IW'(1);

  function automatic logic [N:0][WW-1:0] w_table();
    logic [N:0][WW-1:0] t;
    for (int k = 0; k <= N; k++) t[k] = WW'(fib(k + 1));
    return t;
  endfunction

  localparam logic [N:0][WW-1:0] W_TAB = w_table();

  state_t        state_q, state_d;
  logic [DW-1:0] r_q;
  logic [IW-1:0] idx_q;
  logic [N-1:0]  code_q, code_nx, codeout_q;
  logic [N:0]    code_ext;
  logic          last;
  logic          range_err;

  logic [STEP:0][DW-1:0]   r_ch;
  logic [STEP-1:0]         c_ch;
  logic [STEP-1:0]         c_bit;
  logic [STEP-1:0][DW-1:0] r_nx;
  logic [STEP-1:0]         act;
  logic [STEP-1:0][IW-1:0] k_sel;

  // Bit N is the implicit c[N] = 0 above the codeword.
  assign code_ext = {1'b0, code_q};
  assign r_ch[0]  = r_q;
  assign c_ch[0]  = code_ext[idx_q + ONE];
  assign last     = (idx_q <= STEP_I);

  for (genvar j = 0; j < STEP; j++) begin : g_chain
    assign act[j]   = (IW'(j) < idx_q);
    assign k_sel[j] = act[j] ? idx_q - IW'(j) : ONE;

    fns_enc_slice #(.DW(DW), .WW(WW)) u_slice (
      .r      (r_ch[j]),
      .c_prev (c_ch[j]),
      .w_k    (W_TAB[k_sel[j]]),
      .w_k1   (W_TAB[k_sel[j] + ONE]),
      .c_k    (c_bit[j]),
      .r_next (r_nx[j])
    );

    assign r_ch[j+1] = act[j] ? r_nx[j] : r_ch[j];
    if (j < STEP - 1) begin : g_c
      assign c_ch[j+1] = act[j] ? c_bit[j] : c_ch[j];
    end
  end

  always_comb begin
    code_nx = code_q;
    for (int j = 0; j < STEP; j++)
      if (act[j]) code_nx[k_sel[j][CW-1:0]] = c_bit[j];
    if (last) code_nx[0] = r_ch[STEP][0];
  end

`ifdef FNS_ENC_RANGE_CHK_EN
  localparam logic [63:0] FIB_LIM = fib(N + 2);
  logic err_q;

  assign range_err = (64'(bus.datain) >= FIB_LIM);

  always_ff @(posedge clock) begin
    if (reset)                                              err_q <= 1'b0;
    else if (state_q == IDLE && bus.in_valid && range_err)  err_q <= 1'b1;
    else if (state_q == RUN && last)                        err_q <= 1'b0;
  end

  assign bus.out_err = err_q;
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = range_err ? HOLD : RUN;
      RUN:     if (last) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= '0;
      idx_q     <= IDX_TOP;
      code_q    <= '0;
      codeout_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          r_q    <= bus.datain;
          idx_q  <= IDX_TOP;
          code_q <= '0;
          if (range_err) codeout_q <= '0;
        end
        RUN: begin
          r_q    <= r_ch[STEP];
          code_q <= code_nx;
          if (last) codeout_q <= code_nx;
          else      idx_q     <= idx_q - STEP_I;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.codeout   = codeout_q;
endmodule

// File: tb/tb_fns_encoder_iter.sv
// Self-checking bench: three encoder configs against a rule-level FNS model.
module tb_fns_encoder_iter;
  localparam int NA  = 4;
  localparam int NB  = 27;
  localparam int DWA = fns_pkg::fns_dw(NA);
  localparam int DWB = fns_pkg::fns_dw(NB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int errors = 0;
  int checks = 0;

  fns_encoder_iter_if #(.N(NA)) ia ();
  fns_encoder_iter_if #(.N(NB)) ib ();
  fns_encoder_iter_if #(.N(NB)) ic ();

  fns_encoder_iter #(.N(NA), .STEP(1)) dut_a (.clock(clk), .reset(rst_a), .bus(ia));
  fns_encoder_iter #(.N(NB), .STEP(4)) dut_b (.clock(clk), .reset(rst_b), .bus(ib));
  fns_encoder_iter #(.N(NB), .STEP(1)) dut_c (.clock(clk), .reset(rst_c), .bus(ic));

  function automatic logic [63:0] tfib(int k);
    logic [63:0] a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < k; i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  function automatic logic [63:0] model(int n, logic [63:0] d);
    logic [63:0] r, code;
    bit cp, ck;
    r = d; code = 0; cp = 0;
    for (int k = n - 1; k >= 1; k--) begin
      if (r < tfib(k + 1))       ck = 0;
      else if (r >= tfib(k + 2)) ck = 1;
      else                       ck = cp;
      if (ck) r = r - tfib(k + 1);
      code[k] = ck;
      cp = ck;
    end
    code[0] = r[0];
    return code;
  endfunction

  function automatic logic [63:0] weigh(int n, logic [63:0] code);
    logic [63:0] s;
    s = 0;
    for (int k = 0; k < n; k++) if (code[k]) s = s + tfib(k + 1);
    return s;
  endfunction

  function automatic bit clean(int n, logic [63:0] code);
    logic [2:0] w;
    for (int k = 0; k + 2 < n; k++) begin
      w = {code[k+2], code[k+1], code[k]};
      if (w == 3'b010 || w == 3'b101) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drv(int u, bit v, logic [63:0] d, bit ordy);
    case (u)
      0: begin ia.in_valid = v; ia.datain = d[DWA-1:0]; ia.out_ready = ordy; end
      1: begin ib.in_valid = v; ib.datain = d[DWB-1:0]; ib.out_ready = ordy; end
      default: begin ic.in_valid = v; ic.datain = d[DWB-1:0]; ic.out_ready = ordy; end
    endcase
  endtask

  task automatic set_rst(int u, bit v);
    case (u)
      0: rst_a = v;
      1: rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic peek(int u, output bit ov, output bit ir, output bit bz, output logic [63:0] co);
    case (u)
      0: begin ov = ia.out_valid; ir = ia.in_ready; bz = ia.busy; co = 64'(ia.codeout); end
      1: begin ov = ib.out_valid; ir = ib.in_ready; bz = ib.busy; co = 64'(ib.codeout); end
      default: begin ov = ic.out_valid; ir = ic.in_ready; bz = ic.busy; co = 64'(ic.codeout); end
    endcase
  endtask

  // Accept one word from IDLE, time it to out_valid, drain it. lat=-1 on timeout.
  task automatic run_word(int u, logic [63:0] d, output logic [63:0] co, output int lat);
    bit ov, ir, bz;
    drv(u, 1, d, 0);
    @(posedge clk); #1;
    drv(u, 0, 0, 0);
    lat = -1;
    co  = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      peek(u, ov, ir, bz, co);
      if (ov) begin lat = c; break; end
    end
    drv(u, 0, 0, 1);
    @(posedge clk); #1;
    drv(u, 0, 0, 0);
  endtask

  task automatic test_reset();
    bit ov, ir, bz;
    logic [63:0] co;
    for (int u = 0; u < 3; u++) begin set_rst(u, 1); drv(u, 0, 0, 0); end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      peek(u, ov, ir, bz, co);
      checks++;
      if ({ov, ir, bz} !== 3'b010) begin
        errors++;
        $display("FAIL reset_flags dut%0d: ov/ir/busy=%b%b%b want 010", u, ov, ir, bz);
      end
      checks++;
      if (co !== 64'd0) begin
        errors++;
        $display("FAIL reset_codeout dut%0d: got %h want 0", u, co);
      end
      set_rst(u, 0);
    end
  endtask

  task automatic test_directed();
    logic [63:0] dv[4] = '{64'd7, 64'd3, 64'd5, 64'd0};
    logic [63:0] ev[4] = '{64'hF, 64'h6, 64'hC, 64'h0};
    logic [63:0] co;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_word(0, dv[i], co, lat);
      checks++;
      if (co !== ev[i]) begin
        errors++;
        $display("FAIL n4_vector d=%0d: got %b want %b", dv[i], co[3:0], ev[i][3:0]);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL n4_latency d=%0d: got %0d want 3", dv[i], lat);
      end
    end
    for (int d = 0; d < (1 << DWA); d++) begin
      run_word(0, 64'(d), co, lat);
      checks++;
      if (co !== model(NA, 64'(d)) || weigh(NA, co) != 64'(d)) begin
        errors++;
        $display("FAIL n4_sweep d=%0d: got %b want %b", d, co[3:0], model(NA, 64'(d)));
      end
    end
  endtask

  task automatic test_random(int u, int n, int dw, int cnt, int explat);
    logic [63:0] d, co;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      d = 64'($urandom_range(0, (1 << dw) - 1));
      run_word(u, d, co, lat);
      checks++;
      if (co !== model(n, d)) begin
        errors++;
        $display("FAIL random_code dut%0d d=%0d: got %h want %h", u, d, co, model(n, d));
      end
      checks++;
      if (weigh(n, co) != d) begin
        errors++;
        $display("FAIL random_weight dut%0d: sum %0d want %0d", u, weigh(n, co), d);
      end
      checks++;
      if (!clean(n, co)) begin
        errors++;
        $display("FAIL random_pattern dut%0d: code %b has 010/101", u, co[26:0]);
      end
      checks++;
      if (lat != explat) begin
        errors++;
        $display("FAIL random_latency dut%0d: got %0d want %0d", u, lat, explat);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ov, ir, bz;
    logic [63:0] d, exp, co;
    int lat;
    d   = 64'($urandom_range(0, (1 << DWB) - 1));
    exp = model(NB, d);
    drv(1, 1, d, 0);
    @(posedge clk); #1;
    drv(1, 0, 0, 0);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      peek(1, ov, ir, bz, co);
      if (ov) begin lat = c; break; end
    end
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 7", lat);
    end
    for (int c = 0; c < 20; c++) begin
      drv(1, 1, 64'($urandom_range(0, (1 << DWB) - 1)), 0);
      @(posedge clk); #1;
      peek(1, ov, ir, bz, co);
      checks++;
      if ({ov, ir, bz} !== 3'b101 || co !== exp) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: ov/ir/busy=%b%b%b code=%h want 101 code=%h", c, ov, ir, bz, co, exp);
      end
    end
    drv(1, 0, 0, 1);
    @(posedge clk); #1;
    drv(1, 0, 0, 0);
    peek(1, ov, ir, bz, co);
    checks++;
    if ({ov, ir, bz} !== 3'b010 || co !== exp) begin
      errors++;
      $display("FAIL bp_release: ov/ir/busy=%b%b%b code=%h want 010 code=%h", ov, ir, bz, co, exp);
    end
    @(posedge clk); #1;
    peek(1, ov, ir, bz, co);
    checks++;
    if ({ov, ir, bz} !== 3'b010) begin
      errors++;
      $display("FAIL bp_idle: ov/ir/busy=%b%b%b want 010", ov, ir, bz);
    end
    d = 64'($urandom_range(0, (1 << DWB) - 1));
    run_word(1, d, co, lat);
    checks++;
    if (co !== model(NB, d)) begin
      errors++;
      $display("FAIL bp_next: got %h want %h", co, model(NB, d));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[5];
    logic [63:0] co;
    bit ov, ir, bz, pre_ir, prev_ov;
    int acc, got, last_cyc, cyc;
    for (int i = 0; i < 5; i++) q[i] = 64'($urandom_range(0, (1 << DWB) - 1));
    acc = 0; got = 0; last_cyc = 0; cyc = 0; prev_ov = 0;
    drv(1, 1, q[0], 1);
    peek(1, ov, pre_ir, bz, co);
    while (got < 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (pre_ir && acc < 5) acc++;
      drv(1, acc < 5, (acc < 5) ? q[acc % 5] : 64'd0, 1);
      peek(1, ov, ir, bz, co);
      if (ov) begin
        checks++;
        if (co !== model(NB, q[got]) || prev_ov) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h want %h prev_valid=%b", got, co, model(NB, q[got]), prev_ov);
        end
        if (got > 0) begin
          checks++;
          if (cyc - last_cyc != 9) begin
            errors++;
            $display("FAIL b2b_period word%0d: got %0d want 9", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      prev_ov = ov;
      pre_ir  = ir;
    end
    drv(1, 0, 0, 0);
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 5", got);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    bit ov, ir, bz;
    logic [63:0] d, co;
    int lat;
    run_word(2, 64'd12345, co, lat);
    checks++;
    if (co !== model(NB, 64'd12345)) begin
      errors++;
      $display("FAIL rst_pre: got %h want %h", co, model(NB, 64'd12345));
    end
    drv(2, 1, 64'd200000, 0);
    @(posedge clk); #1;
    drv(2, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    set_rst(2, 1);
    drv(2, 1, 64'd99, 0);
    @(posedge clk); #1;
    peek(2, ov, ir, bz, co);
    checks++;
    if ({ov, ir, bz} !== 3'b010 || co !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_run: ov/ir/busy=%b%b%b code=%h want 010 code=0", ov, ir, bz, co);
    end
    set_rst(2, 0);
    drv(2, 0, 0, 0);
    d = 64'($urandom_range(0, (1 << DWB) - 1));
    run_word(2, d, co, lat);
    checks++;
    if (co !== model(NB, d) || lat != 26) begin
      errors++;
      $display("FAIL rst_after: got %h lat %0d want %h lat 26", co, lat, model(NB, d));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1, NB, DWB, 300, 7);
    test_random(2, NB, DWB, 80, 26);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
